rr_arbiter: RTL and testbench

- Downstream neighbour of the class FIFOs. Drains four input FIFOs (one per priority class) using round-robin arbitration.
- Routes each word by its destination field into one of four output FIFOs. Stalls globally when any output FIFO raises pause.
- Issues read strobes to the upstream FIFOs, consumes their memory read data, and drives write strobes and data into the downstream FIFOs.

---
 rtl/rr_arbiter_pkg.sv | 21 ++
 rtl/rr_pick.sv | 35 +++
 rtl/rr_arbiter.sv | 126 ++++++++++++
 tb/tb_rr_arbiter.sv | 358 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rr_arbiter_pkg.sv
// Shared constants, state encoding and helpers for the round-robin class-FIFO arbiter.
package rr_arbiter_pkg;

   localparam int NUM_PORTS = 4;
   localparam int DEST_MSB  = 5;
   localparam int DEST_LSB  = 4;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACTIVE = 2'd1,
      STALL  = 2'd2
   } arb_state_t;

   function automatic logic [NUM_PORTS-1:0] onehot(input logic [1:0] idx);
      logic [NUM_PORTS-1:0] v;
      v      = '0;
      v[idx] = 1'b1;
      return v;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first requesting port scanning upward from ptr+1.
module rr_pick
   import rr_arbiter_pkg::*;
(
   input  logic [NUM_PORTS-1:0] req,
   input  logic [1:0]           ptr,
   output logic [NUM_PORTS-1:0] gnt_onehot,
   output logic [1:0]           gnt_idx,
   output logic                 any
);

   logic [1:0] cand [NUM_PORTS];

   // cand[k] is the port at distance k+1 from the pointer; the last one wraps back onto ptr.
   genvar gi;
   generate
      for (gi = 0; gi < NUM_PORTS; gi++) begin : g_cand
         assign cand[gi] = ptr + 2'(gi + 1);
      end
   endgenerate

   always_comb begin
      gnt_idx = 2'd0;
      any     = 1'b0;
      // Scan farthest-first so the nearest requester is the one left standing.
      for (int k = NUM_PORTS - 1; k >= 0; k--) begin
         if (req[cand[k]]) begin
            gnt_idx = cand[k];
            any     = 1'b1;
         end
      end
      gnt_onehot = any ? onehot(gnt_idx) : '0;
   end

endmodule

// File: rtl/rr_arbiter.sv
// Drains four class FIFOs round-robin and routes each word by its destination field
// into one of four output FIFOs through a two-stage read/write pipeline.
module rr_arbiter
   import rr_arbiter_pkg::*;
#(
   parameter int DATA_WIDTH = 6,
   parameter int CNT_WIDTH  = 8
)
(
   input  logic                            clk,
   input  logic                            RESET_L,
   input  logic [NUM_PORTS-1:0]            fifo_empty_in,
   input  logic [NUM_PORTS*DATA_WIDTH-1:0] data_in,
   input  logic [NUM_PORTS-1:0]            valid_in,
   input  logic [NUM_PORTS-1:0]            pause_in,
   output logic [NUM_PORTS-1:0]            fifo_rd,
   output logic [NUM_PORTS-1:0]            fifo_wr_out,
   output logic [DATA_WIDTH-1:0]           data_out,
   output logic [1:0]                      grant,
   output logic                            idle,
   output logic                            err_arb,
   output logic [CNT_WIDTH-1:0]            fwd_cnt
);

   arb_state_t             state_reg, state_next;
   logic [1:0]             ptr_reg;
   logic                   pend_vld_reg;
   logic [1:0]             pend_port_reg;
   logic [NUM_PORTS-1:0]   wr_reg;
   logic [DATA_WIDTH-1:0]  dout_reg;
   logic                   err_reg;
   logic [CNT_WIDTH-1:0]   cnt_reg;

   logic [NUM_PORTS-1:0]   pick_onehot;
   logic [1:0]             pick_idx;
   logic                   pick_any;
   logic                   any_req;
   logic                   paused;
   logic                   rd_en;
   logic [DATA_WIDTH-1:0]  word [NUM_PORTS];
   logic [DATA_WIDTH-1:0]  cap_word;
   logic [NUM_PORTS-1:0]   exp_valid;
   logic                   multi_valid;
   logic                   wr_fire;
   logic                   err_next;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_PORTS; gi++) begin : g_word
         assign word[gi] = data_in[gi*DATA_WIDTH +: DATA_WIDTH];
      end
   endgenerate

   rr_pick u_pick (
      .req        (~fifo_empty_in),
      .ptr        (ptr_reg),
      .gnt_onehot (pick_onehot),
      .gnt_idx    (pick_idx),
      .any        (pick_any)
   );

   assign any_req = ~&fifo_empty_in;
   assign paused  = |pause_in;
   // Pause blocks every read: the destination of a word is unknown until it comes back.
   assign rd_en   = RESET_L && (state_reg == ACTIVE) && !paused && pick_any;
   assign fifo_rd = rd_en ? pick_onehot : '0;
   assign grant   = rd_en ? pick_idx : 2'd0;

   assign cap_word    = word[pend_port_reg];
   assign exp_valid   = onehot(pend_port_reg);
   assign multi_valid = (valid_in & (valid_in - 1'b1)) != '0;
   assign wr_fire     = pend_vld_reg && (valid_in == exp_valid);
   assign err_next    = (!pend_vld_reg && (|valid_in))
                     || (pend_vld_reg && (valid_in != exp_valid))
                     || multi_valid;

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE: begin
            if (any_req) state_next = paused ? STALL : ACTIVE;
         end
         ACTIVE: begin
            if (paused)        state_next = STALL;
            else if (!any_req) state_next = IDLE;
         end
         STALL: begin
            if (!paused) state_next = any_req ? ACTIVE : IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!RESET_L) begin
         state_reg     <= IDLE;
         ptr_reg       <= 2'd3;
         pend_vld_reg  <= 1'b0;
         pend_port_reg <= 2'd0;
         wr_reg        <= '0;
         dout_reg      <= '0;
         err_reg       <= 1'b0;
         cnt_reg       <= '0;
      end else begin
         state_reg    <= state_next;
         pend_vld_reg <= rd_en;
         if (rd_en) begin
            ptr_reg       <= pick_idx;
            pend_port_reg <= pick_idx;
         end
         wr_reg  <= wr_fire ? onehot(cap_word[DEST_MSB:DEST_LSB]) : '0;
         err_reg <= err_next;
         if (wr_fire) begin
            dout_reg <= cap_word;
            cnt_reg  <= cnt_reg + 1'b1;
         end
      end
   end

   assign fifo_wr_out = wr_reg;
   assign data_out    = dout_reg;
   assign err_arb     = err_reg;
   assign fwd_cnt     = cnt_reg;
   assign idle        = (state_reg == IDLE) && !pend_vld_reg && (wr_reg == '0);

endmodule

// File: tb/tb_rr_arbiter.sv
// Self-checking bench for rr_arbiter: behavioural input FIFOs plus queues of observed reads/writes.
module tb_rr_arbiter;

   typedef struct {
      int         cyc;
      logic [3:0] v;
      logic [5:0] d;
   } obs_t;

   logic        clk;
   logic        RESET_L;
   logic [3:0]  fifo_empty_in;
   logic [23:0] data_in;
   logic [3:0]  valid_in;
   logic [3:0]  pause_in;
   logic [3:0]  fifo_rd;
   logic [3:0]  fifo_wr_out;
   logic [5:0]  data_out;
   logic [1:0]  grant;
   logic        idle;
   logic        err_arb;
   logic [7:0]  fwd_cnt;

   rr_arbiter dut (
      .clk           (clk),
      .RESET_L       (RESET_L),
      .fifo_empty_in (fifo_empty_in),
      .data_in       (data_in),
      .valid_in      (valid_in),
      .pause_in      (pause_in),
      .fifo_rd       (fifo_rd),
      .fifo_wr_out   (fifo_wr_out),
      .data_out      (data_out),
      .grant         (grant),
      .idle          (idle),
      .err_arb       (err_arb),
      .fwd_cnt       (fwd_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   int err_seen = 0;
   int over_rd  = 0;

   logic [5:0] mq [4][$];
   obs_t       rd_obs [$];
   obs_t       wr_obs [$];
   logic [5:0] exp_wr [$];

   logic [3:0] s_rd, s_wr;
   logic [5:0] s_dout;
   logic [1:0] s_grant;
   logic       s_idle, s_err;
   logic [7:0] s_cnt;

   // One clock: sample outputs at negedge, then play the input FIFOs' response after the edge.
   task automatic step();
      obs_t       o;
      logic [3:0] rd;
      int         p;
      @(negedge clk);
      rd      = fifo_rd;
      s_rd    = fifo_rd;
      s_wr    = fifo_wr_out;
      s_dout  = data_out;
      s_grant = grant;
      s_idle  = idle;
      s_err   = err_arb;
      s_cnt   = fwd_cnt;
      if ((fifo_rd & fifo_empty_in) != 4'b0) over_rd++;
      if (err_arb === 1'b1) err_seen++;
      p = -1;
      if (rd != 4'b0) begin
         o.cyc = cyc; o.v = rd; o.d = {4'b0, grant};
         rd_obs.push_back(o);
         for (int i = 0; i < 4; i++) if (rd[i]) p = i;
      end
      if (fifo_wr_out != 4'b0) begin
         o.cyc = cyc; o.v = fifo_wr_out; o.d = data_out;
         wr_obs.push_back(o);
      end
      @(posedge clk);
      #1;
      cyc++;
      valid_in = 4'b0;
      if (p >= 0 && mq[p].size() > 0) begin
         data_in[p*6 +: 6] = mq[p].pop_front();
         valid_in[p]       = 1'b1;
      end
      for (int i = 0; i < 4; i++) fifo_empty_in[i] = (mq[i].size() == 0);
   endtask

   task automatic do_reset();
      RESET_L  = 1'b0;
      pause_in = 4'b0;
      valid_in = 4'b0;
      for (int i = 0; i < 4; i++) mq[i].delete();
      fifo_empty_in = 4'b1111;
      step();
      step();
      RESET_L = 1'b1;
      rd_obs.delete();
      wr_obs.delete();
      exp_wr.delete();
      err_seen = 0;
      over_rd  = 0;
   endtask

   task automatic test_reset();
      RESET_L  = 1'b0;
      pause_in = 4'b0;
      valid_in = 4'b0;
      for (int i = 0; i < 4; i++) begin
         mq[i].delete();
         mq[i].push_back(6'(i * 5));
      end
      fifo_empty_in = 4'b0000;
      rd_obs.delete();
      wr_obs.delete();
      for (int k = 0; k < 3; k++) begin
         step();
         checks++;
         if (s_rd !== 4'b0 || s_wr !== 4'b0 || s_cnt !== 8'd0) begin
            failures++;
            $display("FAIL reset_hold[%0d]: rd=%b wr=%b cnt=%0d want 0000/0000/0", k, s_rd, s_wr, s_cnt);
         end
      end
      RESET_L = 1'b1;
      for (int k = 0; k < 10 && rd_obs.size() == 0; k++) step();
      checks++;
      if (rd_obs.size() == 0 || rd_obs[0].v !== 4'b0001) begin
         failures++;
         $display("FAIL reset_first_rd: got %b want 0001", (rd_obs.size() > 0) ? rd_obs[0].v : 4'b0);
      end
      for (int k = 0; k < 10; k++) step();
   endtask

   task automatic test_round_robin();
      logic [5:0] w;
      do_reset();
      for (int i = 0; i < 4; i++) begin
         w = {2'(3 - i), 4'(4'hA + i)};
         mq[i].push_back(w);
         exp_wr.push_back(w);
      end
      fifo_empty_in = 4'b0000;
      for (int k = 0; k < 12; k++) step();
      checks++;
      if (rd_obs.size() != 4 || wr_obs.size() != 4) begin
         failures++;
         $display("FAIL rr_counts: reads=%0d writes=%0d want 4/4", rd_obs.size(), wr_obs.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            checks++;
            if (rd_obs[i].v !== (4'b0001 << i) || rd_obs[i].d[1:0] !== 2'(i)
                || rd_obs[i].cyc != rd_obs[0].cyc + i) begin
               failures++;
               $display("FAIL rr_rd[%0d]: got %b grant %0d cyc %0d want %b grant %0d cyc %0d", i,
                        rd_obs[i].v, rd_obs[i].d[1:0], rd_obs[i].cyc, 4'b0001 << i, i, rd_obs[0].cyc + i);
            end
            w = exp_wr.pop_front();
            checks++;
            if (wr_obs[i].v !== (4'b0001 << w[5:4]) || wr_obs[i].d !== w
                || wr_obs[i].cyc != rd_obs[i].cyc + 2) begin
               failures++;
               $display("FAIL rr_wr[%0d]: got %b/%h cyc %0d want %b/%h cyc %0d", i,
                        wr_obs[i].v, wr_obs[i].d, wr_obs[i].cyc, 4'b0001 << w[5:4], w, rd_obs[i].cyc + 2);
            end
         end
      end
      checks++;
      if (s_cnt !== 8'd4 || err_seen != 0 || over_rd != 0) begin
         failures++;
         $display("FAIL rr_cnt: cnt=%0d errs=%0d overreads=%0d want 4/0/0", s_cnt, err_seen, over_rd);
      end
   endtask

   task automatic test_single_port();
      logic [5:0] w;
      int         last_rd;
      int         first_idle;
      do_reset();
      for (int j = 0; j < 3; j++) begin
         w = {2'(j), 4'(j + 3)};
         mq[2].push_back(w);
         exp_wr.push_back(w);
      end
      fifo_empty_in = 4'b1011;
      last_rd    = -1;
      first_idle = -1;
      for (int k = 0; k < 14; k++) begin
         step();
         if (last_rd < 0 && rd_obs.size() == 3) last_rd = rd_obs[2].cyc;
         else if (last_rd >= 0 && first_idle < 0 && s_idle === 1'b1) first_idle = cyc - 1;
      end
      checks++;
      if (rd_obs.size() != 3 || wr_obs.size() != 3) begin
         failures++;
         $display("FAIL single_counts: reads=%0d writes=%0d want 3/3", rd_obs.size(), wr_obs.size());
      end else begin
         for (int j = 0; j < 3; j++) begin
            w = exp_wr.pop_front();
            checks++;
            if (rd_obs[j].v !== 4'b0100 || rd_obs[j].cyc != rd_obs[0].cyc + j || wr_obs[j].d !== w) begin
               failures++;
               $display("FAIL single_seq[%0d]: rd=%b cyc %0d data=%h want 0100 cyc %0d data=%h", j,
                        rd_obs[j].v, rd_obs[j].cyc, wr_obs[j].d, rd_obs[0].cyc + j, w);
            end
         end
      end
      checks++;
      if (first_idle < 0 || first_idle - last_rd != 3) begin
         failures++;
         $display("FAIL single_idle: idle rose %0d cycles after last read want 3", first_idle - last_rd);
      end
      checks++;
      if (over_rd != 0 || err_seen != 0) begin
         failures++;
         $display("FAIL single_clean: overreads=%0d errs=%0d want 0/0", over_rd, err_seen);
      end
   endtask

   task automatic test_pause();
      int rel;
      do_reset();
      mq[0].push_back(6'h11);
      mq[1].push_back(6'h22);
      mq[2].push_back(6'h33);
      fifo_empty_in = 4'b1000;
      for (int k = 0; k < 10 && rd_obs.size() == 0; k++) step();
      pause_in = 4'b0010;
      for (int k = 0; k < 5; k++) step();
      checks++;
      if (rd_obs.size() != 1) begin
         failures++;
         $display("FAIL pause_no_rd: reads=%0d want 1", rd_obs.size());
      end
      checks++;
      if (wr_obs.size() != 1 || wr_obs[0].d !== 6'h11 || wr_obs[0].v !== 4'b0010) begin
         failures++;
         $display("FAIL pause_inflight: writes=%0d data=%h want 1 write of 11 to 0010",
                  wr_obs.size(), (wr_obs.size() > 0) ? wr_obs[0].d : 6'h0);
      end
      pause_in = 4'b0000;
      rel = cyc;
      for (int k = 0; k < 8; k++) step();
      checks++;
      if (rd_obs.size() < 2 || rd_obs[1].v !== 4'b0010 || rd_obs[1].cyc != rel + 1) begin
         failures++;
         $display("FAIL pause_resume: rd=%b cyc %0d want 0010 cyc %0d",
                  (rd_obs.size() > 1) ? rd_obs[1].v : 4'b0, (rd_obs.size() > 1) ? rd_obs[1].cyc : -1, rel + 1);
      end
      checks++;
      if (wr_obs.size() != 3 || over_rd != 0) begin
         failures++;
         $display("FAIL pause_total: writes=%0d overreads=%0d want 3/0", wr_obs.size(), over_rd);
      end
   endtask

   task automatic test_spurious_valid();
      do_reset();
      step();
      step();
      valid_in = 4'b0010;
      for (int k = 0; k < 5; k++) step();
      checks++;
      if (err_seen != 1) begin
         failures++;
         $display("FAIL spurious_err: err cycles=%0d want 1", err_seen);
      end
      checks++;
      if (wr_obs.size() != 0 || s_cnt !== 8'd0) begin
         failures++;
         $display("FAIL spurious_nowr: writes=%0d cnt=%0d want 0/0", wr_obs.size(), s_cnt);
      end
   endtask

   task automatic test_wrap_and_reset();
      logic [5:0] w;
      logic [7:0] cnt255;
      int         bad;
      do_reset();
      for (int j = 0; j < 64; j++)
         for (int i = 0; i < 4; i++) begin
            w = {2'((j + i) % 4), 4'((j * 4 + i) % 16)};
            mq[i].push_back(w);
            exp_wr.push_back(w);
         end
      fifo_empty_in = 4'b0000;
      cnt255 = 8'hxx;
      for (int k = 0; k < 275; k++) begin
         step();
         if (wr_obs.size() == 255 && s_wr != 4'b0) cnt255 = s_cnt;
      end
      checks++;
      if (cnt255 !== 8'd255) begin
         failures++;
         $display("FAIL wrap_255: cnt=%0d want 255", cnt255);
      end
      checks++;
      if (wr_obs.size() != 256 || s_cnt !== 8'd0 || err_seen != 0) begin
         failures++;
         $display("FAIL wrap_end: writes=%0d cnt=%0d errs=%0d want 256/0/0", wr_obs.size(), s_cnt, err_seen);
      end
      bad = 0;
      for (int k = 0; k < wr_obs.size() && exp_wr.size() > 0; k++) begin
         w = exp_wr.pop_front();
         if (wr_obs[k].d !== w || wr_obs[k].v !== (4'b0001 << w[5:4])) bad++;
      end
      checks++;
      if (bad != 0) begin
         failures++;
         $display("FAIL wrap_data: %0d words wrong want 0", bad);
      end
      rd_obs.delete();
      wr_obs.delete();
      mq[3].push_back(6'h2A);
      fifo_empty_in = 4'b0111;
      for (int k = 0; k < 10 && rd_obs.size() == 0; k++) step();
      RESET_L = 1'b0;
      for (int k = 0; k < 3; k++) step();
      RESET_L = 1'b1;
      for (int k = 0; k < 4; k++) step();
      checks++;
      if (rd_obs.size() != 1 || wr_obs.size() != 0) begin
         failures++;
         $display("FAIL midreset_drop: reads=%0d writes=%0d want 1/0", rd_obs.size(), wr_obs.size());
      end
      checks++;
      if (s_wr !== 4'b0 || s_dout !== 6'h0 || s_cnt !== 8'd0 || s_err !== 1'b0
          || s_grant !== 2'd0 || s_idle !== 1'b1) begin
         failures++;
         $display("FAIL midreset_vals: wr=%b dout=%h cnt=%0d err=%b grant=%0d idle=%b want 0000/00/0/0/0/1",
                  s_wr, s_dout, s_cnt, s_err, s_grant, s_idle);
      end
   endtask

   initial begin
      RESET_L       = 1'b0;
      fifo_empty_in = 4'b1111;
      data_in       = 24'h0;
      valid_in      = 4'b0;
      pause_in      = 4'b0;
      test_reset();
      test_round_robin();
      test_single_port();
      test_pause();
      test_spurious_valid();
      test_wrap_and_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
